// File: rtl/gsu_mem_pkg.sv
// Shared types and defaults for the GSU memory responder.
// Latency: n/a (types, constants and a byte-lane helper only).
// Backpressure: n/a.
package gsu_mem_pkg;

    localparam int unsigned       ROM_AW_DEF     = 23;
    localparam int unsigned       RAM_AW_DEF     = 20;
    localparam logic [22:0]       BSRAM_BASE_DEF = 23'h600000;

    // SDRAM handshake sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        REL   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Which requester currently owns the SDRAM channel
    typedef enum logic [1:0] {
        CH_ROM   = 2'd0,
        CH_RAMRD = 2'd1,
        CH_RAMWR = 2'd2
    } chan_t;

    // Pick one byte lane out of a 16-bit SDRAM word
    function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/gsu_mem_responder_if.sv
// Mapper-side and SDRAM-side signal bundle of the GSU memory responder.
// Latency: n/a (wiring only).
// Backpressure: SDRAM side uses a 4-phase req/ack level handshake.
interface gsu_mem_responder_if #(
    parameter int unsigned ROM_AW = 23,
    parameter int unsigned RAM_AW = 20
);
    logic              clkref;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_ce_n;
    logic              rom_oe_n;
    logic              rom_word;
    logic [15:0]       rom_q;
    logic [RAM_AW-1:0] bsram_addr;
    logic [7:0]        bsram_d;
    logic              bsram_ce_n;
    logic              bsram_oe_n;
    logic              bsram_we_n;
    logic [7:0]        bsram_q;
    logic              sd_req;
    logic              sd_ack;
    logic [ROM_AW-1:0] sd_addr;
    logic              sd_we;
    logic [1:0]        sd_be;
    logic [7:0]        sd_din;
    logic [15:0]       sd_dout;
    logic              busy;

    // Environment view: mapper strobes and SDRAM controller responses
    modport master (
        output clkref, rom_addr, rom_ce_n, rom_oe_n, rom_word,
               bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n,
               sd_ack, sd_dout,
        input  rom_q, bsram_q, sd_req, sd_addr, sd_we, sd_be, sd_din, busy
    );

    // Responder view
    modport slave (
        input  clkref, rom_addr, rom_ce_n, rom_oe_n, rom_word,
               bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n,
               sd_ack, sd_dout,
        output rom_q, bsram_q, sd_req, sd_addr, sd_we, sd_be, sd_din, busy
    );

endinterface

// File: rtl/gsu_mem_edge_det.sv
// Falling-edge detector for an active-low strobe.
// Latency: fell is combinational against a one-cycle registered copy.
// Backpressure: none.
module gsu_mem_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic strobe_n,
    output logic fell
);

    logic strobe_q;

    // Keep last cycle's strobe level; idle level is high
    always_ff @(posedge clk) begin
        if (rst) strobe_q <= 1'b1;
        else     strobe_q <= strobe_n;
    end

    assign fell = strobe_q & ~strobe_n;

endmodule

// File: rtl/gsu_mem_responder.sv
// Serves the mapper ROM read port and BSRAM read/write port from one SDRAM channel.
// Latency: launch on first CLKREF slot after a flag sets; data valid the cycle after SD_ACK rises.
// Backpressure: requests queue as pending flags until the 4-phase req/ack handshake completes.
module gsu_mem_responder
    import gsu_mem_pkg::*;
#(
    parameter int unsigned       ROM_AW     = ROM_AW_DEF,
    parameter int unsigned       RAM_AW     = RAM_AW_DEF,
    parameter logic [ROM_AW-1:0] BSRAM_BASE = ROM_AW'(BSRAM_BASE_DEF)
) (
    input logic                clk,
    input logic                rst,
    gsu_mem_responder_if.slave bus
);

    state_t            state;
    chan_t             gnt;

    logic              rom_pend, rd_pend, wr_pend;
    logic [ROM_AW-1:1] rom_lat;
    logic [RAM_AW-1:0] rd_lat;
    logic [RAM_AW-1:0] wr_lat;
    logic [7:0]        wr_dat;

    logic [ROM_AW-1:1] tag;
    logic              tag_vld;
    logic [15:0]       rom_buf;
    logic [7:0]        bsram_q_r;

    logic              sd_req_r;
    logic [ROM_AW-1:0] sd_addr_r;
    logic              sd_we_r;
    logic [1:0]        sd_be_r;
    logic [7:0]        sd_din_r;

    logic              rom_fell, rd_fell, wr_fell;
    logic              rom_access, rom_hit, rom_same, rom_inflight;
    logic              rom_set, rd_set, wr_set;
    logic              any_pend;

    function automatic logic [ROM_AW-1:0] ram_map(input logic [RAM_AW-1:0] a);
        return BSRAM_BASE + ROM_AW'(a);
    endfunction

    gsu_mem_edge_det u_rom_oe (.clk(clk), .rst(rst), .strobe_n(bus.rom_oe_n),   .fell(rom_fell));
    gsu_mem_edge_det u_ram_oe (.clk(clk), .rst(rst), .strobe_n(bus.bsram_oe_n), .fell(rd_fell));
    gsu_mem_edge_det u_ram_we (.clk(clk), .rst(rst), .strobe_n(bus.bsram_we_n), .fell(wr_fell));

    // New-access detection for the three channels
    always_comb begin
        rom_access   = !bus.rom_ce_n && !bus.rom_oe_n;
        rom_hit      = tag_vld && (bus.rom_addr[ROM_AW-1:1] == tag);
        rom_same     = (rom_lat == bus.rom_addr[ROM_AW-1:1]);
        rom_inflight = ((state == REQ) || (state == REL)) && (gnt == CH_ROM);
        // ROM is level-sensitive: a miss on the word already queued or being fetched
        // must not re-arm the flag, otherwise the ack cycle would trigger a repeat fetch.
        rom_set      = rom_access && !rom_hit &&
                       !(rom_same && (rom_inflight || (rom_pend && !rom_fell)));
        rd_set       = !bus.bsram_ce_n && !bus.bsram_oe_n &&
                       (rd_fell || (bus.bsram_addr != rd_lat));
        wr_set       = wr_fell && !bus.bsram_ce_n;
        any_pend     = rom_pend || rd_pend || wr_pend;
    end

    // ROM data is served straight from the one-word buffer
    always_comb begin
        bus.rom_q = rom_buf;
        if (!bus.rom_word) bus.rom_q = {8'h00, byte_sel(rom_buf, bus.rom_addr[0])};
    end

    assign bus.bsram_q = bsram_q_r;
    assign bus.sd_req  = sd_req_r;
    assign bus.sd_addr = sd_addr_r;
    assign bus.sd_we   = sd_we_r;
    assign bus.sd_be   = sd_be_r;
    assign bus.sd_din  = sd_din_r;
    // DRAIN is entered while reset is still held, so reset masks the state term
    assign bus.busy    = !rst && (any_pend || (state != IDLE));

    // Pending flags, arbitration and the SDRAM req/ack sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= bus.sd_ack ? DRAIN : IDLE;
            gnt       <= CH_ROM;
            rom_pend  <= 1'b0;
            rd_pend   <= 1'b0;
            wr_pend   <= 1'b0;
            rom_lat   <= '0;
            rd_lat    <= '0;
            wr_lat    <= '0;
            wr_dat    <= '0;
            tag       <= '0;
            tag_vld   <= 1'b0;
            rom_buf   <= '0;
            bsram_q_r <= '0;
            sd_req_r  <= 1'b0;
            sd_addr_r <= '0;
            sd_we_r   <= 1'b0;
            sd_be_r   <= 2'b00;
            sd_din_r  <= '0;
        end else begin
            if (rom_set) begin
                rom_pend <= 1'b1;
                rom_lat  <= bus.rom_addr[ROM_AW-1:1];
            end
            if (rd_set) begin
                rd_pend <= 1'b1;
                rd_lat  <= bus.bsram_addr;
            end
            if (wr_set) begin
                wr_pend <= 1'b1;
                wr_lat  <= bus.bsram_addr;
                wr_dat  <= bus.bsram_d;
            end

            case (state)
                IDLE: begin
                    if (any_pend && bus.clkref) begin
                        state    <= REQ;
                        sd_req_r <= 1'b1;
                        if (wr_pend) begin
                            gnt       <= CH_RAMWR;
                            sd_addr_r <= ram_map(wr_lat);
                            sd_we_r   <= 1'b1;
                            sd_be_r   <= wr_lat[0] ? 2'b10 : 2'b01;
                            sd_din_r  <= wr_dat;
                        end else if (rd_pend) begin
                            gnt       <= CH_RAMRD;
                            sd_addr_r <= ram_map(rd_lat);
                            sd_we_r   <= 1'b0;
                            sd_be_r   <= rd_lat[0] ? 2'b10 : 2'b01;
                        end else begin
                            gnt       <= CH_ROM;
                            sd_addr_r <= {rom_lat, 1'b0};
                            sd_we_r   <= 1'b0;
                            sd_be_r   <= 2'b11;
                        end
                    end
                end
                REQ: begin
                    if (bus.sd_ack) begin
                        sd_req_r <= 1'b0;
                        state    <= REL;
                        // A fresh event arriving in the ack cycle keeps its flag set
                        case (gnt)
                            CH_ROM: begin
                                rom_buf <= bus.sd_dout;
                                tag     <= sd_addr_r[ROM_AW-1:1];
                                tag_vld <= 1'b1;
                                if (!rom_set) rom_pend <= 1'b0;
                            end
                            CH_RAMRD: begin
                                bsram_q_r <= byte_sel(bus.sd_dout, sd_be_r[1]);
                                if (!rd_set) rd_pend <= 1'b0;
                            end
                            CH_RAMWR: begin
                                if (sd_addr_r[ROM_AW-1:1] == tag) tag_vld <= 1'b0;
                                if (!wr_set) wr_pend <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                REL: begin
                    if (!bus.sd_ack) state <= IDLE;
                end
                DRAIN: begin
                    if (!bus.sd_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsu_mem_responder.sv
// Directed bench for gsu_mem_responder with a small SDRAM controller model.
// Latency: model acks two cycles after it sees SD_REQ.
// Backpressure: model drops ack once SD_REQ falls.
module tb_gsu_mem_responder;
    import gsu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gsu_mem_responder_if #(.ROM_AW(23), .RAM_AW(20)) bus ();

    gsu_mem_responder #(.ROM_AW(23), .RAM_AW(20), .BSRAM_BASE(23'h600000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // SDRAM controller model
    logic        model_en;
    logic        model_ack;
    logic        manual_ack;
    logic [15:0] mem [int];
    logic [22:0] log_addr [$];
    logic        log_we   [$];
    logic [1:0]  log_be   [$];
    logic [7:0]  log_din  [$];
    int          wait_cnt;

    assign bus.sd_ack = model_en ? model_ack : manual_ack;

    initial begin
        model_ack   = 1'b0;
        wait_cnt    = 0;
        bus.sd_dout = 16'h0000;
    end

    // Controller model: ack two cycles after req, apply writes, serve reads
    always begin
        @(posedge clk);
        #2;
        if (!model_en) begin
            model_ack = 1'b0;
            wait_cnt  = 0;
        end else if (bus.sd_req && !model_ack) begin
            wait_cnt++;
            if (wait_cnt >= 2) begin
                int          k;
                logic [15:0] w;
                k = int'(bus.sd_addr >> 1);
                w = mem.exists(k) ? mem[k] : 16'h0000;
                log_addr.push_back(bus.sd_addr);
                log_we.push_back(bus.sd_we);
                log_be.push_back(bus.sd_be);
                log_din.push_back(bus.sd_din);
                if (bus.sd_we) begin
                    if (bus.sd_be[0]) w[7:0]  = bus.sd_din;
                    if (bus.sd_be[1]) w[15:8] = bus.sd_din;
                    mem[k] = w;
                end else begin
                    bus.sd_dout = w;
                end
                model_ack = 1'b1;
                wait_cnt  = 0;
            end
        end else if (!bus.sd_req && model_ack) begin
            model_ack = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (3) tick();
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (bus.busy === 1'b0) else begin
            n_mis++;
            $error("FAIL %s_timeout: busy observed %b expected 0", tag, bus.busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int first_low;
        int n;

        rst            = 1'b1;
        model_en       = 1'b1;
        manual_ack     = 1'b0;
        bus.clkref     = 1'b1;
        bus.rom_addr   = '0;
        bus.rom_ce_n   = 1'b1;
        bus.rom_oe_n   = 1'b1;
        bus.rom_word   = 1'b1;
        bus.bsram_addr = '0;
        bus.bsram_d    = '0;
        bus.bsram_ce_n = 1'b1;
        bus.bsram_oe_n = 1'b1;
        bus.bsram_we_n = 1'b1;
        mem[32'h80]    = 16'hBEEF;
        mem[32'h100]   = 16'h1234;
        mem[32'h180]   = 16'h7777;
        mem[32'h200]   = 16'hA5A5;

        // Reset values
        repeat (3) tick();
        check("rst_rom_q",   32'(bus.rom_q),   32'h0);
        check("rst_bsram_q", 32'(bus.bsram_q), 32'h0);
        check("rst_sd_req",  32'(bus.sd_req),  32'h0);
        check("rst_sd_we",   32'(bus.sd_we),   32'h0);
        check("rst_sd_be",   32'(bus.sd_be),   32'h0);
        check("rst_sd_addr", 32'(bus.sd_addr), 32'h0);
        check("rst_sd_din",  32'(bus.sd_din),  32'h0);
        check("rst_busy",    32'(bus.busy),    32'h0);
        rst = 1'b0;
        tick();

        // 1) ROM word read miss
        bus.rom_word = 1'b1;
        bus.rom_addr = 23'h000100;
        bus.rom_ce_n = 1'b0;
        bus.rom_oe_n = 1'b0;
        wait_idle("t1");
        check("t1_rom_q",    32'(bus.rom_q), 32'h0000BEEF);
        check("t1_req_cnt",  32'(log_addr.size()), 32'd1);
        check("t1_sd_addr",  32'(log_addr[0]), 32'h000100);
        check("t1_sd_be",    32'(log_be[0]), 32'h3);
        check("t1_sd_we",    32'(log_we[0]), 32'h0);

        // 2) byte reads hitting the buffered word
        bus.rom_word = 1'b0;
        tick();
        check("t2_byte_lo", 32'(bus.rom_q), 32'h000000EF);
        bus.rom_addr = 23'h000101;
        tick();
        check("t2_byte_hi", 32'(bus.rom_q), 32'h000000BE);
        bus.rom_oe_n = 1'b1;
        tick();
        bus.rom_oe_n = 1'b0;
        repeat (4) tick();
        check("t2_byte_hi_refall", 32'(bus.rom_q), 32'h000000BE);
        check("t2_req_cnt", 32'(log_addr.size()), 32'd1);
        check("t2_busy",    32'(bus.busy), 32'h0);
        bus.rom_ce_n = 1'b1;
        bus.rom_oe_n = 1'b1;
        tick();

        // 3) BSRAM write then read of the same byte
        bus.bsram_addr = 20'h00003;
        bus.bsram_d    = 8'h5A;
        bus.bsram_ce_n = 1'b0;
        bus.bsram_we_n = 1'b0;
        tick();
        bus.bsram_we_n = 1'b1;
        wait_idle("t3w");
        check("t3w_req_cnt", 32'(log_addr.size()), 32'd2);
        check("t3w_sd_addr", 32'(log_addr[1]), 32'h600003);
        check("t3w_sd_be",   32'(log_be[1]), 32'h2);
        check("t3w_sd_we",   32'(log_we[1]), 32'h1);
        check("t3w_sd_din",  32'(log_din[1]), 32'h5A);
        bus.bsram_oe_n = 1'b0;
        wait_idle("t3r");
        check("t3r_bsram_q", 32'(bus.bsram_q), 32'h5A);
        check("t3r_sd_we",   32'(log_we[2]), 32'h0);
        check("t3r_sd_be",   32'(log_be[2]), 32'h2);
        bus.bsram_oe_n = 1'b1;
        bus.bsram_ce_n = 1'b1;
        tick();

        // 4) ROM miss, BSRAM read and BSRAM write raised together
        n0             = log_addr.size();
        bus.rom_word   = 1'b1;
        bus.rom_addr   = 23'h000200;
        bus.rom_ce_n   = 1'b0;
        bus.rom_oe_n   = 1'b0;
        bus.bsram_addr = 20'h00010;
        bus.bsram_d    = 8'hC3;
        bus.bsram_ce_n = 1'b0;
        bus.bsram_oe_n = 1'b0;
        bus.bsram_we_n = 1'b0;
        tick();
        bus.bsram_we_n = 1'b1;
        tick();
        first_low = -1;
        n = 0;
        while (n < 300) begin
            if (!bus.busy) begin
                first_low = log_addr.size();
                break;
            end
            tick();
            n++;
        end
        check("t4_busy_fall_reqs", 32'(first_low), 32'(n0 + 3));
        check("t4_1st_we",   32'(log_we[n0]),       32'h1);
        check("t4_1st_addr", 32'(log_addr[n0]),     32'h600010);
        check("t4_1st_be",   32'(log_be[n0]),       32'h1);
        check("t4_2nd_we",   32'(log_we[n0+1]),     32'h0);
        check("t4_2nd_addr", 32'(log_addr[n0+1]),   32'h600010);
        check("t4_3rd_addr", 32'(log_addr[n0+2]),   32'h000200);
        check("t4_3rd_be",   32'(log_be[n0+2]),     32'h3);
        check("t4_bsram_q",  32'(bus.bsram_q), 32'hC3);
        check("t4_rom_q",    32'(bus.rom_q),   32'h1234);
        bus.rom_ce_n   = 1'b1;
        bus.rom_oe_n   = 1'b1;
        bus.bsram_ce_n = 1'b1;
        bus.bsram_oe_n = 1'b1;
        tick();

        // 6) launch held off while CLKREF is low
        n0           = log_addr.size();
        bus.clkref   = 1'b0;
        bus.rom_addr = 23'h000300;
        bus.rom_ce_n = 1'b0;
        bus.rom_oe_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_no_req", 32'(bus.sd_req), 32'h0);
        end
        check("t6_busy_waiting", 32'(bus.busy), 32'h1);
        bus.clkref = 1'b1;
        tick();
        check("t6_req_on_slot", 32'(bus.sd_req), 32'h1);
        wait_idle("t6");
        check("t6_rom_q",    32'(bus.rom_q), 32'h7777);
        check("t6_req_cnt",  32'(log_addr.size()), 32'(n0 + 1));
        bus.rom_ce_n = 1'b1;
        bus.rom_oe_n = 1'b1;
        tick();

        // 5) reset while in REQ with SD_ACK high
        n0           = log_addr.size();
        bus.rom_addr = 23'h000400;
        bus.rom_ce_n = 1'b0;
        bus.rom_oe_n = 1'b0;
        n = 0;
        while (!bus.sd_req && n < 20) begin
            tick();
            n++;
        end
        check("t5_req_seen", 32'(bus.sd_req), 32'h1);
        manual_ack = 1'b1;
        model_en   = 1'b0;
        rst        = 1'b1;
        tick();
        check("t5_rst_sd_req",  32'(bus.sd_req),  32'h0);
        check("t5_rst_rom_q",   32'(bus.rom_q),   32'h0);
        check("t5_rst_bsram_q", 32'(bus.bsram_q), 32'h0);
        check("t5_rst_sd_addr", 32'(bus.sd_addr), 32'h0);
        check("t5_rst_sd_be",   32'(bus.sd_be),   32'h0);
        check("t5_rst_busy",    32'(bus.busy),    32'h0);
        check("t5_state",       32'(dut.state),   32'(DRAIN));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_drain_no_req", 32'(bus.sd_req), 32'h0);
        end
        check("t5_drain_state", 32'(dut.state), 32'(DRAIN));
        check("t5_drain_busy",  32'(bus.busy),  32'h1);
        manual_ack = 1'b0;
        model_en   = 1'b1;
        wait_idle("t5");
        check("t5_rom_q",    32'(bus.rom_q), 32'hA5A5);
        check("t5_req_cnt",  32'(log_addr.size()), 32'(n0 + 1));
        check("t5_req_addr", 32'(log_addr[n0]), 32'h000400);
        bus.rom_ce_n = 1'b1;
        bus.rom_oe_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
